// File: rtl/mcu_pkg.sv
// Shared state, opcode, control-field encodings and control word for the multicycle MIPS control unit.
// Pure declarations: no latency, no flow control.
// Imported by mcu_ctrl_decode and multicycle_control_fsm.
package mcu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_AND   = 2'b11;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_ADDI_EX, S_ANDI_EX, S_IMMWB,
      S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

   typedef struct packed {
      logic       pc_en, iord, mem_read, mem_write, ir_write;
      logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       instr_done, illegal;
   } ctrl_t;

   function automatic logic op_known(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mcu_ctrl_decode.sv
// Combinational state -> datapath control word, with stall gating of the commit strobes.
// Latency: zero cycles (pure decode of current state and inputs).
// Backpressure: stall zeroes pc_en/ir_write/reg_write/instr_done except in FETCH/MEMRD/MEMWR.
module mcu_ctrl_decode
   import mcu_pkg::*;
#(
   parameter int ILLEGAL_TRAP = 1
)(
   input  state_t     i_state,
   input  logic [5:0] i_opcode,
   input  logic       i_zero,
   input  logic       i_mem_ready,
   input  logic       i_stall,
   output ctrl_t      o_ctrl
);

   ctrl_t w_cw;
   logic  w_gate;

   always_comb begin
      w_cw   = '0;
      w_gate = 1'b1;
      case (i_state)
         S_FETCH: begin
            w_cw.mem_read  = 1'b1;
            w_cw.alu_src_b = SRCB_FOUR;
            w_cw.pc_src    = PCSRC_ALU;
            w_cw.ir_write  = i_mem_ready;
            w_cw.pc_en     = i_mem_ready;
            w_gate         = 1'b0;
         end
         S_DECODE: begin
            w_cw.alu_src_b  = SRCB_IMM_SL2;
            w_cw.alu_op     = ALU_ADD;
            // Unknown opcodes retire here as a NOP when trapping is disabled.
            w_cw.instr_done = (ILLEGAL_TRAP == 0) && !op_known(i_opcode);
         end
         S_EXEC: begin
            w_cw.alu_src_b = SRCB_RT;
            w_cw.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            w_cw.reg_dst    = 1'b1;
            w_cw.reg_write  = 1'b1;
            w_cw.instr_done = 1'b1;
         end
         S_ADDI_EX: begin
            w_cw.alu_src_b = SRCB_IMM;
            w_cw.alu_op    = ALU_ADD;
         end
         S_ANDI_EX: begin
            w_cw.alu_src_b = SRCB_IMM;
            w_cw.alu_op    = ALU_AND;
         end
         S_IMMWB: begin
            w_cw.reg_write  = 1'b1;
            w_cw.instr_done = 1'b1;
         end
         S_MEMADR: begin
            w_cw.alu_src_a = 1'b1;
            w_cw.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            w_cw.iord     = 1'b1;
            w_cw.mem_read = 1'b1;
            w_gate        = 1'b0;
         end
         S_MEMWB: begin
            w_cw.mem_to_reg = 1'b1;
            w_cw.reg_write  = 1'b1;
            w_cw.instr_done = 1'b1;
         end
         S_MEMWR: begin
            w_cw.iord       = 1'b1;
            w_cw.mem_write  = 1'b1;
            w_cw.instr_done = i_mem_ready;
            w_gate          = 1'b0;
         end
         S_BRANCH: begin
            w_cw.alu_src_a  = 1'b1;
            w_cw.alu_op     = ALU_SUB;
            w_cw.pc_src     = PCSRC_ALUOUT;
            w_cw.pc_en      = (i_opcode == OP_BEQ) ? i_zero : ~i_zero;
            w_cw.instr_done = 1'b1;
         end
         S_JUMP: begin
            w_cw.pc_en      = 1'b1;
            w_cw.pc_src     = PCSRC_JUMP;
            w_cw.instr_done = 1'b1;
         end
         S_TRAP:  w_cw.illegal = 1'b1;
         default: w_cw = '0;
      endcase
      if (w_gate && i_stall) begin
         w_cw.pc_en      = 1'b0;
         w_cw.ir_write   = 1'b0;
         w_cw.reg_write  = 1'b0;
         w_cw.instr_done = 1'b0;
      end
   end

   assign o_ctrl = w_cw;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control FSM; optional retired-instruction counter under MCU_RETIRE_CNT_EN.
// Latency: 3-5 cycles per instruction at mem_ready=1; outputs decoded from the current state.
// Backpressure: mem_ready stretches FETCH/MEMRD/MEMWR; stall freezes every other state.
module multicycle_control_fsm
   import mcu_pkg::*;
#(
   parameter int OPCODE_W     = 6,
   parameter int ALUOP_W      = 2,
   parameter int ILLEGAL_TRAP = 1
`ifdef MCU_RETIRE_CNT_EN
 , parameter int RET_CNT_W    = 32
`endif
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
   input  logic                mem_ready,
   input  logic                stall,
   output logic                pc_en,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                reg_dst,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALUOP_W-1:0]  alu_op,
   output logic [1:0]          pc_src,
   output logic                instr_done,
   output logic                illegal
`ifdef MCU_RETIRE_CNT_EN
 , output logic [RET_CNT_W-1:0] retired
`endif
);

   state_t     r_state;
   ctrl_t      w_cw;
   logic [5:0] w_op;

   assign w_op = opcode[5:0];

   // Successor for states that advance unconditionally once not stalled.
   function automatic state_t f_next(input state_t s, input logic [5:0] op);
      state_t n;
      n = s;
      case (s)
         S_DECODE: begin
            case (op)
               OP_RTYPE:       n = S_EXEC;
               OP_LW, OP_SW:   n = S_MEMADR;
               OP_BEQ, OP_BNE: n = S_BRANCH;
               OP_J:           n = S_JUMP;
               OP_ADDI:        n = S_ADDI_EX;
               OP_ANDI:        n = S_ANDI_EX;
               default:        n = (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
            endcase
         end
         S_EXEC:                n = S_ALUWB;
         S_ADDI_EX, S_ANDI_EX:  n = S_IMMWB;
         S_MEMADR:              n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_ALUWB, S_IMMWB, S_MEMWB, S_BRANCH, S_JUMP: n = S_FETCH;
         default:               n = s;
      endcase
      return n;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  r_state <= S_FETCH;
            S_FETCH: if (mem_ready) r_state <= S_DECODE;
            S_MEMRD: if (mem_ready) r_state <= S_MEMWB;
            S_MEMWR: if (mem_ready) r_state <= S_FETCH;
            S_TRAP:  r_state <= S_TRAP;
            default: if (!stall) r_state <= f_next(r_state, w_op);
         endcase
      end
   end

   mcu_ctrl_decode #(.ILLEGAL_TRAP(ILLEGAL_TRAP)) u_decode (
      .i_state     (r_state),
      .i_opcode    (w_op),
      .i_zero      (zero),
      .i_mem_ready (mem_ready),
      .i_stall     (stall),
      .o_ctrl      (w_cw)
   );

   assign pc_en      = w_cw.pc_en;
   assign iord       = w_cw.iord;
   assign mem_read   = w_cw.mem_read;
   assign mem_write  = w_cw.mem_write;
   assign ir_write   = w_cw.ir_write;
   assign reg_dst    = w_cw.reg_dst;
   assign mem_to_reg = w_cw.mem_to_reg;
   assign reg_write  = w_cw.reg_write;
   assign alu_src_a  = w_cw.alu_src_a;
   assign alu_src_b  = w_cw.alu_src_b;
   assign alu_op     = ALUOP_W'(w_cw.alu_op);
   assign pc_src     = w_cw.pc_src;
   assign instr_done = w_cw.instr_done;
   assign illegal    = w_cw.illegal;

`ifdef MCU_RETIRE_CNT_EN
   logic [RET_CNT_W-1:0] r_retired;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               r_retired <= '0;
      else if (w_cw.instr_done) r_retired <= r_retired + RET_CNT_W'(1);
   end

   assign retired = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: one trapping and one NOP-on-illegal instance share stimulus.
module tb_multicycle_control_fsm;

   localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_BNE = 4, C_J = 5;
   localparam int C_ADDI = 6, C_ANDI = 7, C_ILL = 8;

   typedef struct { bit idle; bit trap; int step; } mst_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = '0;
   logic        zero = 1'b0, mem_ready = 1'b0, stall = 1'b0;
   wire  [16:0] obs_t, obs_n;
   logic [16:0] last_t, last_n;
   logic [31:0] cnt_t, cnt_n;
   mst_t        mt, mn;
   int          n_vec = 0, n_err = 0;
   int          r_iord, r_rw, r_done, r_pcen, r_pcsrc;
`ifdef MCU_RETIRE_CNT_EN
   wire  [31:0] ret_t, ret_n;
`endif

   always #5 clk = ~clk;

   multicycle_control_fsm #(.ILLEGAL_TRAP(1)) dut_t (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .stall(stall),
      .pc_en(obs_t[16]), .iord(obs_t[15]), .mem_read(obs_t[14]), .mem_write(obs_t[13]),
      .ir_write(obs_t[12]), .reg_dst(obs_t[11]), .mem_to_reg(obs_t[10]), .reg_write(obs_t[9]),
      .alu_src_a(obs_t[8]), .alu_src_b(obs_t[7:6]), .alu_op(obs_t[5:4]), .pc_src(obs_t[3:2]),
      .instr_done(obs_t[1]), .illegal(obs_t[0])
`ifdef MCU_RETIRE_CNT_EN
    , .retired(ret_t)
`endif
   );

   multicycle_control_fsm #(.ILLEGAL_TRAP(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready), .stall(stall),
      .pc_en(obs_n[16]), .iord(obs_n[15]), .mem_read(obs_n[14]), .mem_write(obs_n[13]),
      .ir_write(obs_n[12]), .reg_dst(obs_n[11]), .mem_to_reg(obs_n[10]), .reg_write(obs_n[9]),
      .alu_src_a(obs_n[8]), .alu_src_b(obs_n[7:6]), .alu_op(obs_n[5:4]), .pc_src(obs_n[3:2]),
      .instr_done(obs_n[1]), .illegal(obs_n[0])
`ifdef MCU_RETIRE_CNT_EN
    , .retired(ret_n)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int cls(input logic [5:0] op);
      case (op)
         6'b000000: return C_R;
         6'b100011: return C_LW;
         6'b101011: return C_SW;
         6'b000100: return C_BEQ;
         6'b000101: return C_BNE;
         6'b000010: return C_J;
         6'b001000: return C_ADDI;
         6'b001100: return C_ANDI;
         default:   return C_ILL;
      endcase
   endfunction

   function automatic int last_step(input int c);
      case (c)
         C_LW:             return 4;
         C_BEQ, C_BNE, C_J: return 2;
         default:          return 3;
      endcase
   endfunction

   function automatic bit waits_mem(input mst_t s, input int c);
      return (s.step == 0) || (s.step == 3 && (c == C_LW || c == C_SW));
   endfunction

   function automatic mst_t m_reset();
      mst_t s;
      s.idle = 1'b1; s.trap = 1'b0; s.step = 0;
      return s;
   endfunction

   // Expected outputs; bit order pc_en..illegal as wired to obs_*.
   function automatic logic [16:0] mout(input mst_t s, input bit trap_en);
      logic [16:0] o;
      int c;
      o = '0;
      c = cls(opcode);
      if (s.idle) return o;
      if (s.trap) return 17'h1;
      case (s.step)
         0: begin o[14] = 1; o[7:6] = 2'b01; o[12] = mem_ready; o[16] = mem_ready; end
         1: begin o[7:6] = 2'b11; o[1] = (c == C_ILL) && !trap_en; end
         2: case (c)
               C_R:          o[5:4] = 2'b10;
               C_ADDI:       o[7:6] = 2'b10;
               C_ANDI:       begin o[7:6] = 2'b10; o[5:4] = 2'b11; end
               C_LW, C_SW:   begin o[8] = 1; o[7:6] = 2'b10; end
               C_BEQ, C_BNE: begin
                  o[8] = 1; o[5:4] = 2'b01; o[3:2] = 2'b01; o[1] = 1;
                  o[16] = (c == C_BEQ) ? zero : !zero;
               end
               C_J:          begin o[16] = 1; o[3:2] = 2'b10; o[1] = 1; end
               default:      o = '0;
            endcase
         3: case (c)
               C_R:            begin o[11] = 1; o[9] = 1; o[1] = 1; end
               C_ADDI, C_ANDI: begin o[9] = 1; o[1] = 1; end
               C_LW:           begin o[15] = 1; o[14] = 1; end
               C_SW:           begin o[15] = 1; o[13] = 1; o[1] = mem_ready; end
               default:        o = '0;
            endcase
         default: begin o[10] = 1; o[9] = 1; o[1] = 1; end
      endcase
      if (stall && !waits_mem(s, c)) begin
         o[16] = 0; o[12] = 0; o[9] = 0; o[1] = 0;
      end
      return o;
   endfunction

   function automatic mst_t mnext(input mst_t s, input bit trap_en);
      mst_t r;
      int c;
      r = s;
      c = cls(opcode);
      if (s.idle) begin
         r.idle = 1'b0; r.step = 0;
      end else if (!s.trap) begin
         if (waits_mem(s, c)) begin
            if (mem_ready) r.step = (s.step == 0) ? 1 : ((c == C_LW) ? 4 : 0);
         end else if (!stall) begin
            if (s.step == 1 && c == C_ILL) begin
               if (trap_en) r.trap = 1'b1;
               else         r.step = 0;
            end else if (s.step == last_step(c)) r.step = 0;
            else r.step = s.step + 1;
         end
      end
      return r;
   endfunction

   task automatic step_cycle();
      logic [16:0] et, en;
      @(negedge clk);
      et = mout(mt, 1'b1);
      en = mout(mn, 1'b0);
      chk("outs_trap", 32'(obs_t), 32'(et));
      chk("outs_nop", 32'(obs_n), 32'(en));
`ifdef MCU_RETIRE_CNT_EN
      chk("retired_trap", ret_t, cnt_t);
      chk("retired_nop", ret_n, cnt_n);
`endif
      last_t = obs_t;
      last_n = obs_n;
      if (rst_n) begin
         if (et[1]) cnt_t++;
         if (en[1]) cnt_n++;
         mt = mnext(mt, 1'b1);
         mn = mnext(mn, 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      mt = m_reset(); mn = m_reset();
      cnt_t = '0; cnt_n = '0;
      repeat (n) step_cycle();
      rst_n = 1'b1;
   endtask

   // Runs one instruction from FETCH on dut_n; lo = mem_ready-low cycles in MEMRD/MEMWR, st = stall cycles at step 2.
   task automatic run_len(input logic [5:0] op, input int lo, input int st, input bit zr,
                          input string tag, input int exp_len);
      int n, lo_left, st_left;
      bit done;
      n = 0; lo_left = lo; st_left = st; done = 1'b0;
      r_iord = 0; r_rw = 0; r_done = 0; r_pcen = 0; r_pcsrc = 0;
      opcode = op; zero = zr;
      while (!done && n < 40) begin
         mem_ready = 1'b1; stall = 1'b0;
         if (mn.step == 3 && lo_left > 0) begin mem_ready = 1'b0; lo_left--; end
         if (mn.step == 2 && st_left > 0) begin stall = 1'b1; st_left--; end
         step_cycle();
         n++;
         done = last_n[1];
         if (last_n[15]) r_iord++;
         if (last_n[9])  r_rw++;
         if (last_n[1])  begin r_done++; r_pcen = int'(last_n[16]); r_pcsrc = int'(last_n[3:2]); end
      end
      chk(tag, 32'(n), 32'(exp_len));
   endtask

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 9))
         0: return 6'b000000;
         1: return 6'b100011;
         2: return 6'b101011;
         3: return 6'b000100;
         4: return 6'b000101;
         5: return 6'b000010;
         6: return 6'b001000;
         7: return 6'b001100;
         default: return 6'($urandom_range(0, 63));
      endcase
   endfunction

   initial begin
      int trap_age, n_ill, n_wr;
      do_reset(3);
      chk("idle_outs", 32'(obs_t), 32'd0);
      mem_ready = 1'b1;
      step_cycle();
      chk("fetch_rd", 32'(obs_t[14]), 32'd1);

      run_len(6'b000000, 0, 0, 1'b0, "len_r", 4);
      chk("r_rw", 32'(r_rw), 32'd1);
      chk("r_done", 32'(r_done), 32'd1);
      run_len(6'b100011, 3, 0, 1'b0, "len_lw_wait", 8);
      chk("lw_iord", 32'(r_iord), 32'd4);
      run_len(6'b101011, 0, 0, 1'b0, "len_sw", 4);
      run_len(6'b000100, 0, 0, 1'b1, "len_beq", 3);
      chk("beq_pcen", 32'(r_pcen), 32'd1);
      chk("beq_pcsrc", 32'(r_pcsrc), 32'd1);
      run_len(6'b000101, 0, 0, 1'b1, "len_bne", 3);
      chk("bne_pcen", 32'(r_pcen), 32'd0);
      run_len(6'b000010, 0, 0, 1'b0, "len_j", 3);
      chk("j_pcen", 32'(r_pcen), 32'd1);
      chk("j_pcsrc", 32'(r_pcsrc), 32'd2);
      run_len(6'b001000, 0, 0, 1'b0, "len_addi", 4);
      run_len(6'b001100, 0, 0, 1'b0, "len_andi", 4);
      run_len(6'b000000, 0, 2, 1'b0, "len_r_stall", 6);
      chk("stall_rw", 32'(r_rw), 32'd1);

      run_len(6'b111111, 0, 0, 1'b0, "len_nop", 2);
      n_ill = 0; n_wr = 0;
      repeat (20) begin
         step_cycle();
         if (last_t[0]) n_ill++;
         if (last_t[16] | last_t[13] | last_t[12] | last_t[9]) n_wr++;
      end
      chk("trap_illegal", 32'(n_ill), 32'd20);
      chk("trap_writes", 32'(n_wr), 32'd0);

`ifdef MCU_RETIRE_CNT_EN
      do_reset(2);
      step_cycle();
      repeat (10) run_len(6'b001000, 0, 0, 1'b0, "len_addi_cnt", 4);
      chk("retired_10", ret_n, 32'd10);
`endif

      do_reset(2);
      trap_age = 0;
      for (int i = 0; i < 3000; i++) begin
         if ((mt.idle || mt.trap || mt.step == 0) && (mn.idle || mn.step == 0)) opcode = pick_op();
         zero      = ($urandom_range(0, 1) == 1);
         mem_ready = ($urandom_range(0, 9) < 7);
         stall     = ($urandom_range(0, 4) == 0);
         trap_age  = mt.trap ? trap_age + 1 : 0;
         if ($urandom_range(0, 99) == 0 || trap_age > 30) begin
            do_reset(int'($urandom_range(1, 3)));
            trap_age = 0;
         end else begin
            step_cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
